// File: rtl/sprite_writer.sv
`default_nettype none
// ============================================================================
// Module   : sprite_writer
// Purpose  : 1024x9 sprite RAM with a streaming burst write engine, an optional
//            memory clear (SPRITE_WRITER_CLEAR_EN), and a registered read port.
// Revision : 1.0
// ============================================================================
module sprite_writer #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 9,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset,
   input  logic                  i_Start,
   input  logic [ADDR_WIDTH-1:0] i_Base_Addr,
   input  logic [ADDR_WIDTH:0]   i_Length,
   input  logic [DATA_WIDTH-1:0] i_Data,
   input  logic                  i_Valid,
   output logic                  o_Ready,
   output logic                  o_Busy,
   output logic                  o_Done,
   output logic [ADDR_WIDTH:0]   o_Write_Count,
   input  logic                  i_Clear,
   input  logic [ADDR_WIDTH-1:0] i_read_addr,
   output logic [DATA_WIDTH-1:0] o_read_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

`ifdef SPRITE_WRITER_CLEAR_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_CLEAR = 2'd2, S_DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd3} state_t;
`endif

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [ADDR_WIDTH:0]     len_q, len_d;
   logic [ADDR_WIDTH:0]     count_q, count_d;
   logic [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    wr_en;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [ADDR_WIDTH:0]     len_clamped;
   logic [ADDR_WIDTH:0]     count_inc;

`ifndef SPRITE_WRITER_CLEAR_EN
   logic unused_clear;
   assign unused_clear = i_Clear;
`endif

   assign len_clamped = (i_Length > C_DEPTH) ? C_DEPTH : i_Length;
   assign count_inc   = count_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      count_d    = count_q;
      clr_addr_d = clr_addr_q;
      wr_en      = 1'b0;
      wr_addr    = base_q + count_q[ADDR_WIDTH-1:0];
      wr_data    = i_Data;
      case (state_q)
         S_IDLE: begin
            if (i_Start) begin
               base_d  = i_Base_Addr;
               len_d   = len_clamped;
               count_d = '0;
               state_d = (i_Length == '0) ? S_DONE : S_LOAD;
            end
`ifdef SPRITE_WRITER_CLEAR_EN
            else if (i_Clear) begin
               clr_addr_d = '0;
               state_d    = S_CLEAR;
            end
`endif
         end
         S_LOAD: begin
            if (i_Valid) begin
               wr_en   = 1'b1;
               count_d = count_inc;
               if (count_inc == len_q) state_d = S_DONE;
            end
         end
`ifdef SPRITE_WRITER_CLEAR_EN
         S_CLEAR: begin
            wr_en      = 1'b1;
            wr_addr    = clr_addr_q;
            wr_data    = CLEAR_VALUE;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) state_d = S_DONE;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         count_q    <= '0;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         count_q    <= count_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   // Memory has no reset; a reset edge must still suppress an in-flight write.
   always_ff @(posedge i_Clk) begin
      if (wr_en && !i_Reset) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) rd_data_q <= '0;
      else         rd_data_q <= mem[i_read_addr];
   end

   assign o_Ready       = (state_q == S_LOAD);
`ifdef SPRITE_WRITER_CLEAR_EN
   assign o_Busy        = (state_q == S_LOAD) || (state_q == S_CLEAR);
`else
   assign o_Busy        = (state_q == S_LOAD);
`endif
   assign o_Done        = (state_q == S_DONE);
   assign o_Write_Count = count_q;
   assign o_read_data   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_writer
// Purpose  : Directed self-checking bench for sprite_writer.
// Revision : 1.0
// ============================================================================
module tb_sprite_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  base;
   logic [10:0] len;
   logic [8:0]  data;
   logic        valid;
   logic        ready;
   logic        busy;
   logic        done;
   logic [10:0] wcount;
   logic        clear;
   logic [9:0]  raddr;
   logic [8:0]  rdata;

   int n_vec = 0;
   int n_err = 0;

   sprite_writer dut (
      .i_Clk         (clk),
      .i_Reset       (rst),
      .i_Start       (start),
      .i_Base_Addr   (base),
      .i_Length      (len),
      .i_Data        (data),
      .i_Valid       (valid),
      .o_Ready       (ready),
      .o_Busy        (busy),
      .o_Done        (done),
      .o_Write_Count (wcount),
      .i_Clear       (clear),
      .i_read_addr   (raddr),
      .o_read_data   (rdata)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic begin_burst(input logic [9:0] b, input logic [10:0] l);
      start = 1'b1;
      base  = b;
      len   = l;
      step();
      start = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [9:0] a, input logic [8:0] exp);
      raddr = a;
      step();
      chk(tag, 32'(rdata), 32'(exp));
   endtask

   initial begin
      int busy_cycles;
      logic seen_done;
      rst = 1'b1; start = 1'b0; base = '0; len = '0; data = '0;
      valid = 1'b0; clear = 1'b0; raddr = '0;
      step(); step(); step();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_done",  32'(done),  32'd0);
      chk("rst_count", 32'(wcount), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      rst = 1'b0;
      step();

      // Basic burst of four colours
      begin_burst(10'h000, 11'd4);
      chk("b1_ready", 32'(ready), 32'd1);
      chk("b1_busy",  32'(busy),  32'd1);
      valid = 1'b1;
      data = 9'h1FF; step();
      data = 9'h007; step();
      data = 9'h038; step();
      chk("b1_ready_mid", 32'(ready), 32'd1);
      data = 9'h1C0; step();
      valid = 1'b0;
      chk("b1_done",  32'(done),   32'd1);
      chk("b1_count", 32'(wcount), 32'd4);
      chk("b1_ready_end", 32'(ready), 32'd0);
      chk("b1_busy_end",  32'(busy),  32'd0);
      step();
      chk("b1_done_pulse", 32'(done), 32'd0);
      chk("b1_count_hold", 32'(wcount), 32'd4);
      rd("b1_rd0", 10'h000, 9'h1FF);
      rd("b1_rd1", 10'h001, 9'h007);
      rd("b1_rd2", 10'h002, 9'h038);
      rd("b1_rd3", 10'h003, 9'h1C0);

      // Address wrap
      begin_burst(10'h3FE, 11'd4);
      valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         data = 9'(i);
         step();
      end
      valid = 1'b0;
      chk("wr_done", 32'(done), 32'd1);
      rd("wr_3fe", 10'h3FE, 9'd1);
      rd("wr_3ff", 10'h3FF, 9'd2);
      rd("wr_000", 10'h000, 9'd3);
      rd("wr_001", 10'h001, 9'd4);

      // Stall pattern 1,0,0,1,1 with a spurious start mid-burst
      begin_burst(10'h010, 11'd3);
      valid = 1'b1; data = 9'h0A1; step();
      valid = 1'b0; start = 1'b1; base = 10'h200; len = 11'd7; step();
      start = 1'b0;
      chk("st_count_stall", 32'(wcount), 32'd1);
      chk("st_busy_stall",  32'(busy),   32'd1);
      step();
      valid = 1'b1; data = 9'h0A2; step();
      chk("st_done_early", 32'(done), 32'd0);
      data = 9'h0A3; step();
      valid = 1'b0;
      chk("st_done",  32'(done),   32'd1);
      chk("st_count", 32'(wcount), 32'd3);
      rd("st_rd10", 10'h010, 9'h0A1);
      rd("st_rd11", 10'h011, 9'h0A2);
      rd("st_rd12", 10'h012, 9'h0A3);

      // Zero-length burst
      begin_burst(10'h000, 11'd0);
      chk("z_done",  32'(done),   32'd1);
      chk("z_busy",  32'(busy),   32'd0);
      chk("z_count", 32'(wcount), 32'd0);
      step();
      chk("z_done_pulse", 32'(done), 32'd0);
      rd("z_mem0", 10'h000, 9'd3);

      // Over-long burst clamps to the full depth
      begin_burst(10'h100, 11'd1100);
      valid = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         data = 9'(i);
         step();
      end
      valid = 1'b0;
      chk("cl_done",  32'(done),   32'd1);
      chk("cl_count", 32'(wcount), 32'd1024);
      step();
      chk("cl_ready", 32'(ready), 32'd0);
      rd("cl_100", 10'h100, 9'h000);
      rd("cl_3ff", 10'h3FF, 9'h0FF);
      rd("cl_000", 10'h000, 9'h100);
      rd("cl_0ff", 10'h0FF, 9'h1FF);

      // Reset after two of five words
      begin_burst(10'h020, 11'd5);
      valid = 1'b1;
      data = 9'h011; step();
      data = 9'h022; step();
      valid = 1'b0; rst = 1'b1; step();
      chk("ra_busy",  32'(busy),   32'd0);
      chk("ra_done",  32'(done),   32'd0);
      chk("ra_count", 32'(wcount), 32'd0);
      rst = 1'b0; step();
      chk("ra_done_after", 32'(done), 32'd0);
      rd("ra_rd20", 10'h020, 9'h011);
      rd("ra_rd21", 10'h021, 9'h022);
      rd("ra_rd22", 10'h022, 9'h122);
      begin_burst(10'h020, 11'd1);
      valid = 1'b1; data = 9'h1AB; step();
      valid = 1'b0;
      chk("ra_next_done",  32'(done),   32'd1);
      chk("ra_next_count", 32'(wcount), 32'd1);
      rd("ra_next_rd", 10'h020, 9'h1AB);

      // Read during write to the same address returns the old word
      begin_burst(10'h021, 11'd1);
      raddr = 10'h021; valid = 1'b1; data = 9'h155; step();
      valid = 1'b0;
      chk("rdw_old", 32'(rdata), 32'h022);
      step();
      chk("rdw_new", 32'(rdata), 32'h155);

`ifdef SPRITE_WRITER_CLEAR_EN
      clear = 1'b1; step();
      clear = 1'b0;
      busy_cycles = 0;
      seen_done = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (busy) busy_cycles++;
         if (done) begin
            seen_done = 1'b1;
            break;
         end
         step();
      end
      chk("clr_done", 32'(seen_done), 32'd1);
      chk("clr_busy_cycles", 32'(busy_cycles), 32'd1024);
      step();
      chk("clr_done_pulse", 32'(done), 32'd0);
      rd("clr_rd000", 10'h000, 9'h000);
      rd("clr_rd021", 10'h021, 9'h000);
      rd("clr_rd3ff", 10'h3FF, 9'h000);
`else
      busy_cycles = 0;
      seen_done = 1'b0;
      clear = 1'b1; step();
      clear = 1'b0;
      chk("nclr_busy", 32'(busy), 32'd0);
      chk("nclr_done", 32'(done), 32'd0);
      step();
      chk("nclr_busy2", 32'(busy), 32'd0);
      rd("nclr_rd021", 10'h021, 9'h155);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
